// File: rtl/clkmon_multi.sv
// Multi-channel clock monitor: counts synchronised rising edges of each monitored clock
// over a window of ref_clk cycles, then filters loss/frequency status with hysteresis.
module clkmon_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 12,
  parameter int WIN_LEN     = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int LOSS_WIN    = 2,
  parameter int GOOD_WIN    = 3
) (
  input  logic                    ref_clk,
  input  logic                    rst,
  input  logic                    det_en,
  input  logic [NUM_CH-1:0]       clk_to_det,
  input  logic [NUM_CH*CNT_W-1:0] lo_thr,
  input  logic [NUM_CH*CNT_W-1:0] hi_thr,
  input  logic [NUM_CH-1:0]       sticky_clr,
  output logic [NUM_CH-1:0]       clk_loss,
  output logic [NUM_CH-1:0]       freq_err,
  output logic [NUM_CH-1:0]       sticky_loss,
  output logic [NUM_CH*CNT_W-1:0] meas_cnt,
  output logic                    meas_vld
);

  // state | meaning
  // IDLE  | detection off, edge counters held at 0
  // ARM   | SYNC_STAGES+1 cycles flushing stale synchroniser content
  // RUN   | window counter running, edges counted
  localparam int WIN_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int ARM_W   = $clog2(SYNC_STAGES + 1);
  localparam int HYS_MAX = (LOSS_WIN > GOOD_WIN) ? LOSS_WIN : GOOD_WIN;
  localparam int HYS_W   = $clog2(HYS_MAX + 1);
  localparam int HYS_W1  = HYS_W + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);
  localparam logic [HYS_W:0]   LOSS_LIM = HYS_W1'(LOSS_WIN);
  localparam logic [HYS_W:0]   GOOD_LIM = HYS_W1'(GOOD_WIN);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} state_t;

  typedef struct packed {
    logic             st;
    logic [HYS_W-1:0] fc;
    logic [HYS_W-1:0] pc;
  } hyst_t;

  localparam hyst_t HYST_RST = hyst_t'({1'b1, {(2*HYS_W){1'b0}}});

  // Saturating fail/pass counters; a status only flips once its run length is reached.
  function automatic hyst_t hyst_step(input hyst_t h, input logic fail);
    hyst_t          n;
    logic [HYS_W:0] inc;
    n = h;
    if (fail) begin
      inc  = {1'b0, h.fc} + 1'b1;
      n.pc = '0;
      if (inc >= LOSS_LIM) begin
        n.fc = HYS_W'(LOSS_WIN);
        n.st = 1'b1;
      end else begin
        n.fc = inc[HYS_W-1:0];
      end
    end else begin
      inc  = {1'b0, h.pc} + 1'b1;
      n.fc = '0;
      if (inc >= GOOD_LIM) begin
        n.pc = HYS_W'(GOOD_WIN);
        n.st = 1'b0;
      end else begin
        n.pc = inc[HYS_W-1:0];
      end
    end
    return n;
  endfunction

  state_t           state;
  logic [WIN_W-1:0] win_cnt;
  logic [ARM_W-1:0] arm_cnt;
  logic             close_q;
  logic             win_close;

  assign win_close = (state == RUN) && det_en && (win_cnt == WIN_LAST);

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      win_cnt  <= '0;
      arm_cnt  <= '0;
      close_q  <= 1'b0;
      meas_vld <= 1'b0;
    end else begin
      meas_vld <= close_q;
      close_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (det_en) begin
            state   <= ARM;
            arm_cnt <= '0;
          end
        end
        ARM: begin
          if (!det_en) begin
            state <= IDLE;
          end else if (arm_cnt == ARM_LAST) begin
            state   <= RUN;
            win_cnt <= '0;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!det_en) begin
            state <= IDLE;
          end else if (win_cnt == WIN_LAST) begin
            win_cnt <= '0;
            close_q <= 1'b1;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   edge_det;
    logic [CNT_W-1:0]       edge_cnt;
    logic [CNT_W-1:0]       meas_q;
    logic [CNT_W-1:0]       lo;
    logic [CNT_W-1:0]       hi;
    logic [CNT_W:0]         cnt_sum;
    logic [CNT_W-1:0]       cnt_sat;
    logic                   loss_win;
    logic                   bad_win;
    hyst_t                  loss_h;
    hyst_t                  freq_h;
    hyst_t                  loss_n;
    hyst_t                  freq_n;
    logic                   sticky_q;

    assign lo       = lo_thr[i*CNT_W +: CNT_W];
    assign hi       = hi_thr[i*CNT_W +: CNT_W];
    assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign cnt_sum  = {1'b0, edge_cnt} + {{CNT_W{1'b0}}, edge_det};
    assign cnt_sat  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    assign loss_win = (meas_q == '0);
    assign bad_win  = (meas_q < lo) || (meas_q > hi);
    assign loss_n   = hyst_step(loss_h, loss_win);
    assign freq_n   = hyst_step(freq_h, bad_win);

    always_ff @(posedge ref_clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
        hist_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], clk_to_det[i]};
        hist_q <= sync_q[SYNC_STAGES-1];
      end
    end

    // The edge seen in the closing cycle still belongs to the closing window.
    always_ff @(posedge ref_clk or posedge rst) begin
      if (rst) begin
        edge_cnt <= '0;
        meas_q   <= '0;
      end else if (state != RUN || !det_en) begin
        edge_cnt <= '0;
      end else if (win_close) begin
        meas_q   <= cnt_sat;
        edge_cnt <= '0;
      end else begin
        edge_cnt <= cnt_sat;
      end
    end

    always_ff @(posedge ref_clk or posedge rst) begin
      if (rst) begin
        loss_h   <= HYST_RST;
        freq_h   <= HYST_RST;
        sticky_q <= 1'b0;
      end else begin
        if (close_q) begin
          loss_h <= loss_n;
          freq_h <= freq_n;
        end
        sticky_q <= (sticky_q & ~sticky_clr[i]) | (close_q & loss_n.st & ~loss_h.st);
      end
    end

    assign clk_loss[i]                 = loss_h.st;
    assign freq_err[i]                 = freq_h.st;
    assign sticky_loss[i]              = sticky_q;
    assign meas_cnt[i*CNT_W +: CNT_W] = meas_q;
  end

endmodule
